// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over a
// req/ready handshake and holds the IF/ID register that feeds decode.
// A one-entry skid buffer catches a word that completes while decode stalls,
// and the DISCARD state swallows a fetch made stale by a redirect that
// arrived while the request was still waiting on memory.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_instruction,
  output logic        id_valid,
  output logic [31:0] debug_pc
);

  // FETCH: request outstanding; HOLD: skid full, no request;
  // DISCARD: outstanding request is stale and its data will be dropped.
  // Being in DISCARD is the "redirect pending" condition.
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;

  logic        fetch_done;
  logic [31:0] pc_plus4;

  assign imem_req       = (state_q != S_HOLD);
  assign imem_addr      = pc_q;
  assign debug_pc       = pc_q;
  assign id_pc_4        = id_pc4_q;
  assign id_instruction = id_instr_q;
  assign id_valid       = id_valid_q;

  assign fetch_done = imem_req & imem_ready;
  assign pc_plus4   = pc_q + 32'd4;

  // Next-state selection: stall beats redirect, redirect beats normal flow.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;
    redir_pc_d = redir_pc_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;

    if (shouldStall) begin
      // IF/ID frozen; a redirect request is ignored while decode stalls.
      unique case (state_q)
        S_FETCH: begin
          if (fetch_done) begin
            skid_d     = imem_rdata;
            skid_pc4_d = pc_plus4;
            pc_d       = pc_plus4;
            state_d    = S_HOLD;
          end
        end
        S_DISCARD: begin
          if (fetch_done) begin
            pc_d    = redir_pc_q;
            state_d = S_FETCH;
          end
        end
        default: ;
      endcase
    end else if (shouldJumpOrBranch) begin
      // Squash whatever would enter decode; no delay slot.
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      skid_d     = '0;
      skid_pc4_d = '0;
      if (fetch_done || (state_q == S_HOLD)) begin
        pc_d    = jumpOrBranchPc;
        state_d = S_FETCH;
      end else begin
        // Request still waiting: keep the address stable, remember the
        // newest target and throw the eventual data away.
        redir_pc_d = jumpOrBranchPc;
        state_d    = S_DISCARD;
      end
    end else begin
      unique case (state_q)
        S_HOLD: begin
          id_instr_d = skid_q;
          id_pc4_d   = skid_pc4_q;
          id_valid_d = 1'b1;
          state_d    = S_FETCH;
        end
        S_FETCH: begin
          if (fetch_done) begin
            id_instr_d = imem_rdata;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
          end else begin
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
          end
        end
        S_DISCARD: begin
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
          if (fetch_done) begin
            pc_d    = redir_pc_q;
            state_d = S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // State, PC, skid buffer and IF/ID registers; reset abandons any request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      skid_q     <= '0;
      skid_pc4_q <= '0;
      redir_pc_q <= '0;
      id_instr_q <= NOP_INSTR;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
      redir_pc_q <= redir_pc_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule
